// File: rtl/cbus_arb_pkg.sv
// Shared CBUS field widths, arbiter FSM state codes and index helpers.
package cbus_arb_pkg;

    localparam int ADDR_W  = 32;
    localparam int BCNT_W  = 10;
    localparam int BEN_W   = 4;
    localparam int DATA_W  = 32;
    localparam int AMODE_W = 2;
    localparam int MSTID_W = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR_BURST = 2'd1;
    localparam logic [1:0] ST_RD_WAIT  = 2'd2;

    // Requester index following idx, wrapping back to 0 at num.
    function automatic int rr_next(input int idx, input int num);
        int nxt;
        nxt = idx + 1;
        if (nxt >= num) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cbus_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module cbus_rr_arb
    import cbus_arb_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_MST-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] pos_s;

    // Scan upward from the pointer with wrap; the first asserted request is taken.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        pos_s = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            pos_s = IDX_W'((int'(ptr) + i) % NUM_MST);
            if (!any && req[pos_s]) begin
                any        = 1'b1;
                gnt[pos_s] = 1'b1;
                idx        = pos_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/cbus_mstr_arb.sv
// Shares one CBUS master port between NUM_MST requesters; the grant is held
// for a whole write burst or read, and a watchdog frees a read that never returns.
module cbus_mstr_arb
    import cbus_arb_pkg::*;
#(
    parameter int           NUM_MST    = 2,
    parameter logic [7:0]   MSTID_BASE = 8'h10,
    parameter int           TMO_CYC    = 1024
) (
    input  logic                        aclk,
    input  logic                        areset_n,
    input  logic [NUM_MST-1:0]          rq_req,
    input  logic [NUM_MST-1:0]          rq_cmd,
    input  logic [NUM_MST-1:0]          rq_first,
    input  logic [NUM_MST-1:0]          rq_last,
    input  logic [ADDR_W*NUM_MST-1:0]   rq_address,
    input  logic [BCNT_W*NUM_MST-1:0]   rq_bytecnt,
    input  logic [BEN_W*NUM_MST-1:0]    rq_byten,
    input  logic [AMODE_W*NUM_MST-1:0]  rq_amode,
    input  logic [DATA_W*NUM_MST-1:0]   rq_wdata,
    output logic [NUM_MST-1:0]          rq_waccept,
    output logic [NUM_MST-1:0]          rq_rresp,
    output logic [DATA_W-1:0]           rq_rdatap,
    output logic                        cbus_m_req,
    output logic                        cbus_m_cmd,
    output logic                        cbus_m_first,
    output logic                        cbus_m_last,
    output logic [ADDR_W-1:0]           cbus_m_address,
    output logic [BCNT_W-1:0]           cbus_m_bytecnt,
    output logic [BEN_W-1:0]            cbus_m_byten,
    output logic [AMODE_W-1:0]          cbus_m_amode,
    output logic [DATA_W-1:0]           cbus_m_wdata,
    output logic [MSTID_W-1:0]          cbus_m_mstid,
    input  logic                        cbus_m_waccept,
    input  logic                        cbus_m_rresp,
    input  logic [DATA_W-1:0]           cbus_m_rdatap,
    output logic [NUM_MST-1:0]          arb_gnt,
    output logic                        arb_tmo_err
);

    localparam int               IDX_W   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int               WD_W    = $clog2(TMO_CYC);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TMO_CYC - 1);

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [NUM_MST-1:0]  gnt_nxt_s;
    logic [IDX_W-1:0]    gnt_idx_r;
    logic [IDX_W-1:0]    idx_nxt_s;
    logic [IDX_W-1:0]    ptr_r;
    logic [IDX_W-1:0]    ptr_nxt_s;
    logic [WD_W-1:0]     wdog_r;
    logic [WD_W-1:0]     wdog_nxt_s;
    logic                tmo_nxt_s;

    logic [NUM_MST-1:0]  cand_s;
    logic [NUM_MST-1:0]  pick_gnt_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_any_s;
    logic                pick_rd_s;
    logic                gnt_req_s;
    logic                gnt_last_s;

    // New transactions only start on a first beat; a burst already in flight never re-arbitrates.
    assign cand_s     = rq_req & rq_first;
    assign pick_rd_s  = |(pick_gnt_s & rq_cmd);
    assign gnt_req_s  = |(arb_gnt & rq_req);
    assign gnt_last_s = |(arb_gnt & rq_last);

    cbus_rr_arb #(
        .NUM_MST (NUM_MST),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req (cand_s),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Next-state logic: grant in IDLE, release on last accepted beat, last read response or watchdog.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = arb_gnt;
        idx_nxt_s   = gnt_idx_r;
        ptr_nxt_s   = ptr_r;
        wdog_nxt_s  = '0;
        tmo_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    gnt_nxt_s   = pick_gnt_s;
                    idx_nxt_s   = pick_idx_s;
                    ptr_nxt_s   = IDX_W'(rr_next(int'(pick_idx_s), NUM_MST));
                    state_nxt_s = pick_rd_s ? ST_RD_WAIT : ST_WR_BURST;
                end else begin
                    gnt_nxt_s   = '0;
                end
            end
            ST_WR_BURST: begin
                if (gnt_req_s && gnt_last_s && cbus_m_waccept) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_WR_BURST;
                end
            end
            ST_RD_WAIT: begin
                if (cbus_m_rresp && gnt_last_s) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = '0;
                end else if (cbus_m_rresp) begin
                    wdog_nxt_s  = '0;
                end else if (wdog_r == WD_LAST) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = '0;
                    tmo_nxt_s   = 1'b1;
                end else begin
                    wdog_nxt_s  = wdog_r + {{(WD_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = '0;
            end
        endcase
    end

    // Arbiter state, grant, round-robin pointer, watchdog and timeout pulse registers.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_r     <= ST_IDLE;
            arb_gnt     <= '0;
            gnt_idx_r   <= '0;
            ptr_r       <= '0;
            wdog_r      <= '0;
            arb_tmo_err <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            arb_gnt     <= gnt_nxt_s;
            gnt_idx_r   <= idx_nxt_s;
            ptr_r       <= ptr_nxt_s;
            wdog_r      <= wdog_nxt_s;
            arb_tmo_err <= tmo_nxt_s;
        end
    end

    // Read data is retimed once; the granted requester samples it the cycle after its rresp.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rq_rdatap <= '0;
        end else begin
            rq_rdatap <= cbus_m_rdatap;
        end
    end

    // Downstream field mux: AND-OR select by one-hot grant, so everything is zero while IDLE.
    always_comb begin
        cbus_m_req     = 1'b0;
        cbus_m_cmd     = 1'b0;
        cbus_m_first   = 1'b0;
        cbus_m_last    = 1'b0;
        cbus_m_address = '0;
        cbus_m_bytecnt = '0;
        cbus_m_byten   = '0;
        cbus_m_amode   = '0;
        cbus_m_wdata   = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            cbus_m_req     = cbus_m_req   | (rq_req[i]   & arb_gnt[i]);
            cbus_m_cmd     = cbus_m_cmd   | (rq_cmd[i]   & arb_gnt[i]);
            cbus_m_first   = cbus_m_first | (rq_first[i] & arb_gnt[i]);
            cbus_m_last    = cbus_m_last  | (rq_last[i]  & arb_gnt[i]);
            cbus_m_address = cbus_m_address | (rq_address[i*ADDR_W +: ADDR_W]  & {ADDR_W{arb_gnt[i]}});
            cbus_m_bytecnt = cbus_m_bytecnt | (rq_bytecnt[i*BCNT_W +: BCNT_W]  & {BCNT_W{arb_gnt[i]}});
            cbus_m_byten   = cbus_m_byten   | (rq_byten[i*BEN_W +: BEN_W]      & {BEN_W{arb_gnt[i]}});
            cbus_m_amode   = cbus_m_amode   | (rq_amode[i*AMODE_W +: AMODE_W]  & {AMODE_W{arb_gnt[i]}});
            cbus_m_wdata   = cbus_m_wdata   | (rq_wdata[i*DATA_W +: DATA_W]    & {DATA_W{arb_gnt[i]}});
        end
        if (state_r != ST_IDLE) begin
            cbus_m_mstid = MSTID_BASE + MSTID_W'(gnt_idx_r);
        end else begin
            cbus_m_mstid = '0;
        end
    end

    // Handshake returns go to the granted requester only, and only in the matching phase.
    always_comb begin
        rq_waccept = '0;
        rq_rresp   = '0;
        case (state_r)
            ST_WR_BURST: rq_waccept = arb_gnt & {NUM_MST{cbus_m_waccept}};
            ST_RD_WAIT:  rq_rresp   = arb_gnt & {NUM_MST{cbus_m_rresp}};
            default: begin
                rq_waccept = '0;
                rq_rresp   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cbus_mstr_arb.sv
// Directed bench for cbus_mstr_arb with a write-beat and read-data scoreboard.
module tb_cbus_mstr_arb;

    localparam int NM = 2;

    logic              aclk = 1'b0;
    logic              areset_n;
    logic [NM-1:0]     rq_req, rq_cmd, rq_first, rq_last;
    logic [32*NM-1:0]  rq_address;
    logic [10*NM-1:0]  rq_bytecnt;
    logic [4*NM-1:0]   rq_byten;
    logic [2*NM-1:0]   rq_amode;
    logic [32*NM-1:0]  rq_wdata;
    logic [NM-1:0]     rq_waccept, rq_rresp;
    logic [31:0]       rq_rdatap;
    logic              cbus_m_req, cbus_m_cmd, cbus_m_first, cbus_m_last;
    logic [31:0]       cbus_m_address;
    logic [9:0]        cbus_m_bytecnt;
    logic [3:0]        cbus_m_byten;
    logic [1:0]        cbus_m_amode;
    logic [31:0]       cbus_m_wdata;
    logic [7:0]        cbus_m_mstid;
    logic              cbus_m_waccept, cbus_m_rresp;
    logic [31:0]       cbus_m_rdatap;
    logic [NM-1:0]     arb_gnt;
    logic              arb_tmo_err;

    always #5 aclk = ~aclk;

    cbus_mstr_arb #(.NUM_MST(NM), .MSTID_BASE(8'h10), .TMO_CYC(8)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .rq_req(rq_req), .rq_cmd(rq_cmd), .rq_first(rq_first), .rq_last(rq_last),
        .rq_address(rq_address), .rq_bytecnt(rq_bytecnt), .rq_byten(rq_byten),
        .rq_amode(rq_amode), .rq_wdata(rq_wdata),
        .rq_waccept(rq_waccept), .rq_rresp(rq_rresp), .rq_rdatap(rq_rdatap),
        .cbus_m_req(cbus_m_req), .cbus_m_cmd(cbus_m_cmd), .cbus_m_first(cbus_m_first),
        .cbus_m_last(cbus_m_last), .cbus_m_address(cbus_m_address),
        .cbus_m_bytecnt(cbus_m_bytecnt), .cbus_m_byten(cbus_m_byten),
        .cbus_m_amode(cbus_m_amode), .cbus_m_wdata(cbus_m_wdata), .cbus_m_mstid(cbus_m_mstid),
        .cbus_m_waccept(cbus_m_waccept), .cbus_m_rresp(cbus_m_rresp), .cbus_m_rdatap(cbus_m_rdatap),
        .arb_gnt(arb_gnt), .arb_tmo_err(arb_tmo_err)
    );

    typedef struct packed {
        logic [7:0]  mstid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        first;
        logic        last;
    } beat_t;

    beat_t       sb_q[$];
    logic [31:0] rd_q[$];
    int          total = 0;
    int          bad   = 0;
    int          beats_seen = 0;
    bit          rd_chk_pend = 1'b0;

    // Requester models: each walks its own burst beat by beat on rq_waccept.
    bit          busy[NM];
    bit          is_rd[NM];
    int          nb[NM];
    int          bi[NM];
    logic [31:0] base[NM];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int i, input int b);
        return base[i] ^ 32'hA5A5_0000 ^ 32'(b) ^ (32'(i) << 12);
    endfunction

    task automatic drive_rq();
        for (int i = 0; i < NM; i++) begin
            if (busy[i]) begin
                rq_req[i]              = 1'b1;
                rq_cmd[i]              = is_rd[i];
                rq_first[i]            = (bi[i] == 0);
                rq_last[i]             = (bi[i] == nb[i] - 1);
                rq_address[i*32 +: 32] = base[i] + 32'(4 * bi[i]);
                rq_bytecnt[i*10 +: 10] = 10'(4 * nb[i]);
                rq_byten[i*4 +: 4]     = 4'hF;
                rq_amode[i*2 +: 2]     = 2'b01;
                rq_wdata[i*32 +: 32]   = wd(i, bi[i]);
            end else begin
                rq_req[i]              = 1'b0;
                rq_cmd[i]              = 1'b0;
                rq_first[i]            = 1'b0;
                rq_last[i]             = 1'b0;
                rq_address[i*32 +: 32] = 32'h0;
                rq_bytecnt[i*10 +: 10] = 10'h0;
                rq_byten[i*4 +: 4]     = 4'h0;
                rq_amode[i*2 +: 2]     = 2'b00;
                rq_wdata[i*32 +: 32]   = 32'h0;
            end
        end
    endtask

    task automatic start_wr(input int i, input int n, input logic [31:0] b);
        busy[i] = 1'b1; is_rd[i] = 1'b0; nb[i] = n; bi[i] = 0; base[i] = b;
        for (int k = 0; k < n; k++)
            sb_q.push_back({8'h10 + 8'(i), b + 32'(4 * k), wd(i, k), (k == 0), (k == n - 1)});
        drive_rq();
    endtask

    task automatic start_rd(input int i, input logic [31:0] b);
        busy[i] = 1'b1; is_rd[i] = 1'b1; nb[i] = 1; bi[i] = 0; base[i] = b;
        drive_rq();
    endtask

    // One clock: scoreboard checks at negedge, requester models advance just after posedge.
    task automatic step();
        bit    acc[NM];
        bit    rsp[NM];
        beat_t got;
        @(negedge aclk);
        if (rd_chk_pend) begin
            rd_chk_pend = 1'b0;
            if (rd_q.size() > 0) chk("rdatap", rq_rdatap, rd_q.pop_front());
            else                 chk("rd_q_underflow", rd_q.size(), 1);
        end
        if (cbus_m_req && !cbus_m_cmd && cbus_m_waccept) begin
            beats_seen++;
            got = {cbus_m_mstid, cbus_m_address, cbus_m_wdata, cbus_m_first, cbus_m_last};
            if (sb_q.size() > 0) chk("wr_beat", got, sb_q.pop_front());
            else                 chk("sb_underflow", sb_q.size(), 1);
        end
        if (rq_rresp != '0) rd_chk_pend = 1'b1;
        chk("gnt_onehot0", $onehot0(arb_gnt), 1'b1);
        chk("route_excl", (rq_waccept | rq_rresp) & ~arb_gnt, 2'b00);
        for (int i = 0; i < NM; i++) begin
            acc[i] = rq_waccept[i];
            rsp[i] = rq_rresp[i];
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < NM; i++) begin
            if (busy[i] && !is_rd[i] && acc[i]) begin
                bi[i]++;
                if (bi[i] == nb[i]) busy[i] = 1'b0;
            end else if (busy[i] && is_rd[i] && rsp[i]) begin
                busy[i] = 1'b0;
            end
        end
        drive_rq();
    endtask

    task automatic wait_done(input int i, input int maxc, input string tag, output int n);
        n = 0;
        while (busy[i] && n < maxc) begin
            step();
            n++;
        end
        chk(tag, busy[i], 1'b0);
    endtask

    initial begin
        int n;
        int b0;
        areset_n       = 1'b0;
        cbus_m_waccept = 1'b1;
        cbus_m_rresp   = 1'b0;
        cbus_m_rdatap  = 32'hDEAD_BEEF;
        for (int i = 0; i < NM; i++) busy[i] = 1'b0;
        drive_rq();
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_gnt", arb_gnt, 2'b00);
        chk("rst_req", cbus_m_req, 1'b0);
        chk("rst_mstid", cbus_m_mstid, 8'h00);
        chk("rst_rdatap", rq_rdatap, 32'h0);
        chk("rst_tmo", arb_tmo_err, 1'b0);
        areset_n      = 1'b1;
        cbus_m_rdatap = 32'h0;
        step();

        // Two simultaneous first beats with pointer 0: req0 then req1, one idle cycle between.
        start_wr(0, 2, 32'h0000_2000);
        start_wr(1, 2, 32'h0000_3000);
        step();
        chk("t2_gnt0", arb_gnt, 2'b01);
        chk("t2_mstid0", cbus_m_mstid, 8'h10);
        wait_done(0, 10, "t2_r0_done", n);
        chk("t2_idle_gap", arb_gnt, 2'b00);
        step();
        chk("t2_gnt1", arb_gnt, 2'b10);
        chk("t2_mstid1", cbus_m_mstid, 8'h11);
        wait_done(1, 10, "t2_r1_done", n);
        start_wr(0, 1, 32'h0000_2100);
        start_wr(1, 1, 32'h0000_3100);
        step();
        chk("t2_ptr_back_0", arb_gnt, 2'b01);
        wait_done(0, 10, "t2_p0_done", n);
        wait_done(1, 10, "t2_p1_done", n);

        // Req0 alone, 4-beat write with waccept held high.
        start_wr(0, 4, 32'h0000_1000);
        step();
        chk("t1_gnt", arb_gnt, 2'b01);
        chk("t1_mstid", cbus_m_mstid, 8'h10);
        chk("t1_req", cbus_m_req, 1'b1);
        b0 = beats_seen;
        wait_done(0, 20, "t1_done", n);
        chk("t1_cycles", n, 4);
        chk("t1_beats", beats_seen - b0, 4);
        chk("t1_idle_after", arb_gnt, 2'b00);

        // Req1 read arrives while req0 writes; no handshakes leak to req1 until its grant.
        start_wr(0, 3, 32'h0000_4000);
        step();
        chk("t3_gnt0", arb_gnt, 2'b01);
        start_rd(1, 32'h0000_5000);
        step();
        chk("t3_waccept1", rq_waccept[1], 1'b0);
        chk("t3_mstid_w", cbus_m_mstid, 8'h10);
        wait_done(0, 10, "t3_w_done", n);
        step();
        chk("t3_gnt1", arb_gnt, 2'b10);
        chk("t3_cmd", cbus_m_cmd, 1'b1);
        chk("t3_addr", cbus_m_address, 32'h0000_5000);
        chk("t3_mstid_r", cbus_m_mstid, 8'h11);
        step();
        chk("t3_rd_hold", arb_gnt, 2'b10);
        cbus_m_rresp  = 1'b1;
        cbus_m_rdatap = 32'hCAFE_0001;
        rd_q.push_back(32'hCAFE_0001);
        #1;
        chk("t3_rresp_route", rq_rresp, 2'b10);
        step();
        cbus_m_rresp  = 1'b0;
        cbus_m_rdatap = 32'h0;
        chk("t3_released", arb_gnt, 2'b00);
        step();

        // waccept low for 3 cycles mid-burst: grant held, no switch to req1.
        start_wr(0, 4, 32'h0000_6000);
        step();
        chk("t4_gnt0", arb_gnt, 2'b01);
        b0 = beats_seen;
        start_wr(1, 1, 32'h0000_7000);
        step();
        cbus_m_waccept = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold_gnt", arb_gnt, 2'b01);
        end
        cbus_m_waccept = 1'b1;
        wait_done(0, 10, "t4_w_done", n);
        chk("t4_beats", beats_seen - b0, 4);
        step();
        chk("t4_gnt1", arb_gnt, 2'b10);
        wait_done(1, 10, "t4_r1_done", n);

        // Read that never answers: watchdog release after 8 cycles, req0 regranted.
        start_rd(0, 32'h0000_8000);
        step();
        chk("t5_gnt0", arb_gnt, 2'b01);
        n = 0;
        while (!arb_tmo_err && n < 20) begin
            step();
            n++;
        end
        chk("t5_tmo_cycles", n, 8);
        chk("t5_tmo_pulse", arb_tmo_err, 1'b1);
        chk("t5_gnt_rel", arb_gnt, 2'b00);
        chk("t5_req_drop", cbus_m_req, 1'b0);
        step();
        chk("t5_tmo_one", arb_tmo_err, 1'b0);
        chk("t5_regrant", arb_gnt, 2'b01);
        cbus_m_rresp  = 1'b1;
        cbus_m_rdatap = 32'h1234_5678;
        rd_q.push_back(32'h1234_5678);
        step();
        cbus_m_rresp  = 1'b0;
        cbus_m_rdatap = 32'h0;
        chk("t5_done", arb_gnt, 2'b00);
        step();

        // Reset during beat 2 of a write burst; the pointer must come back to 0.
        start_wr(0, 4, 32'h0000_9000);
        step();
        chk("t6_gnt0", arb_gnt, 2'b01);
        step();
        step();
        areset_n = 1'b0;
        #1;
        chk("t6_rst_gnt", arb_gnt, 2'b00);
        chk("t6_rst_req", cbus_m_req, 1'b0);
        busy[0] = 1'b0;
        drive_rq();
        sb_q.delete();
        @(posedge aclk);
        #1;
        areset_n = 1'b1;
        start_wr(0, 1, 32'h0000_A000);
        start_wr(1, 1, 32'h0000_B000);
        step();
        chk("t6_ptr_reset", arb_gnt, 2'b01);
        wait_done(0, 10, "t6_r0_done", n);
        wait_done(1, 10, "t6_r1_done", n);
        step();

        chk("sb_drained", sb_q.size(), 0);
        chk("rd_drained", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
